// File: rtl/mac_result_collector.sv
// ---------------------------------------------------------------------------
// mac_result_collector
//
// Purpose:
//   Consumer end of the MAC output interface. Sums NUM_NEIGH successive
//   four-lane MAC results per node (neighbour aggregation). Each lane is then
//   post-processed: arithmetic right shift by SHIFT, optional ReLU, and
//   saturation to OUT_SIZE signed bits. The resulting four features are
//   streamed out one lane per valid/ready handshake.
//
// Optional feature:
//   COLLECT_RELU_EN  when defined, negative shifted sums are clamped to 0
//                    before saturation. When undefined, no activation is
//                    applied and the full signed range is used.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   mac_ready      in   mac_out0..3 valid this cycle
//   mac_out0..3    in   signed MAC lane results, MAC_OUT_SIZE bits each
//   collect_stall  out  upstream must not raise in_ready while high
//   res_valid      out  res_data holds a valid feature
//   res_ready      in   downstream accepts res_data
//   res_data       out  signed post-processed feature, OUT_SIZE bits
//   res_idx        out  lane index of res_data (0..3)
//   res_last       out  high together with res_idx == 3
//   node_done      out  one-cycle pulse when a node's result bank is loaded
//   overflow       out  sticky: a final sample was dropped
// ---------------------------------------------------------------------------
module mac_result_collector #(
  parameter int MAC_OUT_SIZE = 13,
  parameter int NUM_NEIGH    = 4,
  parameter int ACC_SIZE     = 16,
  parameter int SHIFT        = 4,
  parameter int OUT_SIZE     = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mac_ready,
  input  logic signed [MAC_OUT_SIZE-1:0] mac_out0,
  input  logic signed [MAC_OUT_SIZE-1:0] mac_out1,
  input  logic signed [MAC_OUT_SIZE-1:0] mac_out2,
  input  logic signed [MAC_OUT_SIZE-1:0] mac_out3,
  output logic                           collect_stall,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [OUT_SIZE-1:0]     res_data,
  output logic [1:0]                     res_idx,
  output logic                           res_last,
  output logic                           node_done,
  output logic                           overflow
);

  localparam int CNT_W = (NUM_NEIGH > 2) ? $clog2(NUM_NEIGH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NEIGH - 1);

  localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'((1 << (OUT_SIZE - 1)) - 1);
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ACC_SIZE'(-(1 << (OUT_SIZE - 1)));

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [1:0]                     idx_q, idx_d;
  logic                           node_done_q, node_done_d;
  logic                           overflow_q, overflow_d;
  logic signed [ACC_SIZE-1:0]     acc_q  [4];
  logic signed [ACC_SIZE-1:0]     acc_d  [4];
  logic signed [OUT_SIZE-1:0]     bank_q [4];
  logic signed [OUT_SIZE-1:0]     bank_d [4];

  logic signed [MAC_OUT_SIZE-1:0] mac_in   [4];
  logic signed [ACC_SIZE-1:0]     sum      [4];
  logic signed [OUT_SIZE-1:0]     post_val [4];

  logic hs, hs_last, is_final, accept;

  assign mac_in[0] = mac_out0;
  assign mac_in[1] = mac_out1;
  assign mac_in[2] = mac_out2;
  assign mac_in[3] = mac_out3;

  // Per-lane datapath: sign-extended add, then shift / activation / saturate.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [ACC_SIZE-1:0] shifted;
      logic signed [ACC_SIZE-1:0] act;

      assign sum[gi] = acc_q[gi] +
                       {{(ACC_SIZE - MAC_OUT_SIZE){mac_in[gi][MAC_OUT_SIZE-1]}}, mac_in[gi]};
      assign shifted = sum[gi] >>> SHIFT;

      always_comb begin
        act = shifted;
`ifdef COLLECT_RELU_EN
        if (shifted < 0) begin
          act = '0;
        end
`endif
        if (act > SAT_MAX) begin
          post_val[gi] = SAT_MAX[OUT_SIZE-1:0];
        end else if (act < SAT_MIN) begin
          post_val[gi] = SAT_MIN[OUT_SIZE-1:0];
        end else begin
          post_val[gi] = act[OUT_SIZE-1:0];
        end
      end
    end
  endgenerate

  // A final sample may only overwrite the bank once it is empty, or in the
  // very cycle its last lane leaves.
  assign hs       = (state_q == FULL) && res_ready;
  assign hs_last  = hs && (idx_q == 2'd3);
  assign is_final = mac_ready && (cnt_q == LAST_CNT);
  assign accept   = is_final && ((state_q == EMPTY) || hs_last);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    node_done_d = 1'b0;
    overflow_d  = overflow_q;
    acc_d       = acc_q;
    bank_d      = bank_q;

    if (hs) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        state_d = EMPTY;
      end
    end

    if (mac_ready) begin
      if (!is_final) begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end else if (accept) begin
        bank_d      = post_val;
        for (int k = 0; k < 4; k++) begin
          acc_d[k] = '0;
        end
        cnt_d       = '0;
        state_d     = FULL;
        idx_d       = 2'd0;
        node_done_d = 1'b1;
      end else begin
        // Bank still busy: drop the final sample, keep the partial sum so
        // the upstream can resend it.
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      node_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        acc_q[k]  <= '0;
        bank_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      node_done_q <= node_done_d;
      overflow_q  <= overflow_d;
      acc_q       <= acc_d;
      bank_q      <= bank_d;
    end
  end

  assign res_valid     = (state_q == FULL);
  assign res_data      = (state_q == FULL) ? bank_q[idx_q] : '0;
  assign res_idx       = idx_q;
  assign res_last      = (state_q == FULL) && (idx_q == 2'd3);
  assign node_done     = node_done_q;
  assign overflow      = overflow_q;
  assign collect_stall = (cnt_q == LAST_CNT) && (state_q == FULL);

endmodule

// File: tb/tb_mac_result_collector.sv
// ---------------------------------------------------------------------------
// tb_mac_result_collector
//
// Bench for mac_result_collector (NUM_NEIGH=4, SHIFT=4, OUT_SIZE=5). A
// transaction-level model tracks the per-node sums and the queue of features
// still waiting to leave the bank; every handshake seen on the output is
// collected and compared against that model and against fixed values.
// Honours COLLECT_RELU_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mac_result_collector;

  typedef struct packed {
    logic signed [31:0] data;
    logic [1:0]         idx;
    logic               last;
  } feat_t;

  logic              clk;
  logic              rst_n;
  logic              mac_ready;
  logic signed [12:0] mac_out0, mac_out1, mac_out2, mac_out3;
  logic              collect_stall;
  logic              res_valid;
  logic              res_ready;
  logic signed [4:0] res_data;
  logic [1:0]        res_idx;
  logic              res_last;
  logic              node_done;
  logic              overflow;

  mac_result_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mac_ready    (mac_ready),
    .mac_out0     (mac_out0),
    .mac_out1     (mac_out1),
    .mac_out2     (mac_out2),
    .mac_out3     (mac_out3),
    .collect_stall(collect_stall),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_idx      (res_idx),
    .res_last     (res_last),
    .node_done    (node_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int    n_cmp  = 0;
  int    n_fail = 0;

  // Reference model state
  feat_t pend[$];   // features loaded into the bank, not yet handshaken
  feat_t exp_q[$];  // features expected to have left, in order
  feat_t got[$];    // features observed leaving the DUT
  int    m_sum[4];
  int    m_cnt;
  bit    m_ovf;
  int    nd_exp;
  int    nd_seen;

`ifdef COLLECT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  // floor(s / 16), optional ReLU, clamp to [-16, 15]
  function automatic int post_model(input int s);
    int t;
    t = s / 16;
    if (s < 0 && (s % 16) != 0) t = t - 1;
    if (RELU && t < 0) t = 0;
    if (t > 15) t = 15;
    if (t < -16) t = -16;
    return t;
  endfunction

  function automatic int rnd_lane();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic clear_model();
    pend.delete(); exp_q.delete(); got.delete();
    for (int k = 0; k < 4; k++) m_sum[k] = 0;
    m_cnt = 0; m_ovf = 0; nd_exp = 0; nd_seen = 0;
  endtask

  // One clock cycle: called at a falling edge, drives inputs, observes the
  // outputs, advances the model, returns at the next falling edge.
  task automatic step(input bit mr, input int l0, input int l1, input int l2,
                      input int l3, input bit rr);
    int    l[4];
    bit    hs, fin, ok;
    feat_t f;
    l = '{l0, l1, l2, l3};
    mac_ready = mr;
    mac_out0  = 13'(l0);
    mac_out1  = 13'(l1);
    mac_out2  = 13'(l2);
    mac_out3  = 13'(l3);
    res_ready = rr;
    #1;
    if (res_valid && res_ready) begin
      f.data = res_data;
      f.idx  = res_idx;
      f.last = res_last;
      got.push_back(f);
      $display("[%0t] out idx=%0d data=%0d last=%0d", $time, res_idx, res_data, res_last);
    end
    if (node_done) nd_seen++;
    hs  = (pend.size() > 0) && rr;
    fin = mr && (m_cnt == 3);
    ok  = fin && ((pend.size() == 0) || (pend.size() == 1 && hs));
    if (hs) exp_q.push_back(pend.pop_front());
    if (mr) begin
      if (!fin) begin
        for (int k = 0; k < 4; k++) m_sum[k] += l[k];
        m_cnt++;
      end else if (ok) begin
        for (int k = 0; k < 4; k++) begin
          f.data = post_model(m_sum[k] + l[k]);
          f.idx  = 2'(k);
          f.last = (k == 3);
          pend.push_back(f);
          m_sum[k] = 0;
        end
        m_cnt = 0;
        nd_exp++;
      end else begin
        m_ovf = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rr);
  endtask

  task automatic rst_assert();
    #2;
    rst_n     = 0;
    mac_ready = 0;
    res_ready = 0;
    clear_model();
  endtask

  task automatic rst_release();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_assert();
    #1;
    n_cmp++;
    if ({res_valid, res_idx, res_data, res_last, node_done, overflow, collect_stall} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b idx=%0d data=%0d last=%0b nd=%0b ovf=%0b stall=%0b required all 0",
               res_valid, res_idx, res_data, res_last, node_done, overflow, collect_stall);
    end
    rst_release();
  endtask

  task automatic test_basic();
    int lit[4];
    lit = RELU ? '{15, 0, 5, 2} : '{15, -13, 5, 2};
    for (int s = 0; s < 4; s++) step(1, 100, -50, 20, 8, 1);
    n_cmp++;
    if (!(res_valid === 1'b1 && node_done === 1'b1 && res_data === 5'sd15)) begin
      n_fail++;
      $display("FAIL basic_latency: got v=%0b nd=%0b data=%0d required v=1 nd=1 data=15",
               res_valid, node_done, res_data);
    end
    idle(6, 1);
    n_cmp++;
    if (got.size() !== 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d required 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp++;
      if (got[i].data !== lit[i] || got[i].idx !== 2'(i) || got[i].last !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_lane%0d: got data=%0d idx=%0d last=%0b required data=%0d idx=%0d last=%0b",
                 i, got[i].data, got[i].idx, got[i].last, lit[i], i, (i == 3));
      end
    end
    n_cmp++;
    if (nd_seen !== 1) begin
      n_fail++;
      $display("FAIL basic_node_done: got %0d pulses required 1", nd_seen);
    end
  endtask

  task automatic test_backpressure();
    rst_assert(); rst_release(); got.delete();
    for (int s = 0; s < 4; s++) step(1, 100, -50, 20, 8, 0);
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== 5'sd15 || res_idx !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%0b data=%0d idx=%0d required v=1 data=15 idx=0",
                 c, res_valid, res_data, res_idx);
      end
      if (c < 5) step(0, 0, 0, 0, 0, 0);
    end
    idle(6, 1);
    n_cmp++;
    if (got.size() !== exp_q.size() || got.size() !== 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d required 4 (model %0d)", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_lane%0d: got data=%0d idx=%0d required data=%0d idx=%0d",
                 i, got[i].data, got[i].idx, exp_q[i].data, exp_q[i].idx);
      end
    end
  endtask

  task automatic test_stall_overflow();
    int b[4];
    rst_assert(); rst_release();
    for (int s = 0; s < 4; s++) step(1, rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane(), 0);
    for (int k = 0; k < 4; k++) b[k] = rnd_lane();
    for (int s = 0; s < 3; s++) step(1, b[0], b[1], b[2], b[3], 0);
    n_cmp++;
    if (collect_stall !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_raise: got stall=%0b ovf=%0b required stall=1 ovf=0", collect_stall, overflow);
    end
    step(1, b[0], b[1], b[2], b[3], 0);
    n_cmp++;
    if (overflow !== 1'b1 || collect_stall !== 1'b1 || res_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_drop: got ovf=%0b stall=%0b idx=%0d required ovf=1 stall=1 idx=0",
               overflow, collect_stall, res_idx);
    end
    idle(4, 1);
    n_cmp++;
    if (res_valid !== 1'b0 || collect_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got v=%0b stall=%0b required v=0 stall=0", res_valid, collect_stall);
    end
    step(1, b[0], b[1], b[2], b[3], 1);
    idle(6, 1);
    n_cmp++;
    if (got.size() !== 8 || exp_q.size() !== 8 || overflow !== 1'b1 || nd_seen !== 2) begin
      n_fail++;
      $display("FAIL stall_totals: got feats=%0d ovf=%0b nd=%0d required feats=8 ovf=1 nd=2",
               got.size(), overflow, nd_seen);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_feat%0d: got data=%0d idx=%0d required data=%0d idx=%0d",
                 i, got[i].data, got[i].idx, exp_q[i].data, exp_q[i].idx);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b[4];
    rst_assert(); rst_release();
    for (int s = 0; s < 4; s++) step(1, rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane(), 0);
    for (int k = 0; k < 4; k++) b[k] = rnd_lane();
    for (int s = 0; s < 3; s++) step(1, b[0], b[1], b[2], b[3], 0);
    for (int s = 0; s < 3; s++) begin
      step(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_valid%0d: got %0b required 1", s, res_valid);
      end
    end
    step(1, b[0], b[1], b[2], b[3], 1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_idx !== 2'd0 || node_done !== 1'b1 || overflow !== 1'b0 ||
        pend.size() == 0 || res_data !== pend[0].data[4:0]) begin
      n_fail++;
      $display("FAIL b2b_swap: got v=%0b idx=%0d nd=%0b ovf=%0b data=%0d required v=1 idx=0 nd=1 ovf=0 data=%0d",
               res_valid, res_idx, node_done, overflow, res_data,
               (pend.size() > 0) ? pend[0].data : 0);
    end
    idle(6, 1);
    n_cmp++;
    if (got.size() !== 8 || exp_q.size() !== 8 || overflow !== 1'b0 || nd_seen !== 2) begin
      n_fail++;
      $display("FAIL b2b_totals: got feats=%0d ovf=%0b nd=%0d required feats=8 ovf=0 nd=2",
               got.size(), overflow, nd_seen);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_feat%0d: got data=%0d idx=%0d required data=%0d idx=%0d",
                 i, got[i].data, got[i].idx, exp_q[i].data, exp_q[i].idx);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst_assert(); rst_release();
    // Reset after two partial samples.
    for (int s = 0; s < 2; s++) step(1, 1000, -1000, 500, 700, 1);
    rst_assert();
    #1;
    n_cmp++;
    if ({res_valid, res_idx, res_data, res_last, node_done, overflow, collect_stall} !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_partial: got v=%0b idx=%0d data=%0d stall=%0b required all 0",
               res_valid, res_idx, res_data, collect_stall);
    end
    rst_release();
    // Reset during a drain at res_idx == 2.
    for (int s = 0; s < 4; s++) step(1, 100, -50, 20, 8, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (res_idx !== 2'd2 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_drain_pre: got idx=%0d v=%0b required idx=2 v=1", res_idx, res_valid);
    end
    rst_assert();
    #1;
    n_cmp++;
    if ({res_valid, res_idx, res_data, res_last, node_done, overflow, collect_stall} !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_drain: got v=%0b idx=%0d data=%0d last=%0b required all 0",
               res_valid, res_idx, res_data, res_last);
    end
    rst_release();
    for (int s = 0; s < 4; s++) step(1, 16, 16, 16, 16, 1);
    idle(6, 1);
    n_cmp++;
    if (got.size() !== 4 || nd_seen !== 1) begin
      n_fail++;
      $display("FAIL rst_after_count: got feats=%0d nd=%0d required feats=4 nd=1", got.size(), nd_seen);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++;
      if (got[i].data !== 4 || got[i].idx !== 2'(i)) begin
        n_fail++;
        $display("FAIL rst_after_lane%0d: got data=%0d idx=%0d required data=4 idx=%0d",
                 i, got[i].data, got[i].idx, i);
      end
    end
  endtask

  task automatic test_random();
    rst_assert(); rst_release();
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 99) < 45), rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane(),
           ($urandom_range(0, 99) < 60));
    end
    idle(8, 1);
    n_cmp++;
    if (got.size() !== exp_q.size() || pend.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d required %0d (pending %0d)", got.size(), exp_q.size(), pend.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_feat%0d: got data=%0d idx=%0d last=%0b required data=%0d idx=%0d last=%0b",
                 i, got[i].data, got[i].idx, got[i].last, exp_q[i].data, exp_q[i].idx, exp_q[i].last);
      end
    end
    n_cmp++;
    if (overflow !== m_ovf || nd_seen !== nd_exp) begin
      n_fail++;
      $display("FAIL rand_flags: got ovf=%0b nd=%0d required ovf=%0b nd=%0d", overflow, nd_seen, m_ovf, nd_exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk       = 0;
    rst_n     = 0;
    mac_ready = 0;
    res_ready = 0;
    mac_out0  = '0;
    mac_out1  = '0;
    mac_out2  = '0;
    mac_out3  = '0;
    clear_model();
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_stall_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Consumer end of the MAC output interface. Captures out0..out3 on each mac_ready pulse.
- Accumulates NUM_NEIGH successive MAC results per node (GNN neighbour aggregation).
- Post-processes each lane: activation, right shift, saturation to the next layer's MAC_IN_SIZE.
- Streams the four node features out one lane per valid/ready handshake, toward the next layer's feature buffer.

Parameters:
- MAC_OUT_SIZE, 13, width of each signed MAC result lane.
- NUM_NEIGH, 4, MAC results summed per node; must be 2 or more.
- ACC_SIZE, 16, signed accumulator width; must be at least MAC_OUT_SIZE + clog2(NUM_NEIGH).
- SHIFT, 4, arithmetic right-shift applied to the accumulated sum before saturation.
- OUT_SIZE, 5, signed output feature width (equals next-layer MAC_IN_SIZE).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mac_ready  in  1  one-cycle qualifier: mac_out0..3 valid this cycle.
- mac_out0..mac_out3  in  MAC_OUT_SIZE each  signed MAC lane results.
- collect_stall  out  1  upstream must not raise in_ready while high.
- res_valid  out  1  res_data holds a valid feature.
- res_ready  in  1  downstream accepts res_data.
- res_data  out  OUT_SIZE  signed post-processed feature.
- res_idx  out  2  lane index of res_data (0..3).
- res_last  out  1  high with res_idx==3.
- node_done  out  1  one-cycle pulse when a node's result bank is loaded.
- overflow  out  1  sticky: a final sample was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc0..3 = 0, cnt = 0, state = EMPTY.
  - res_valid = 0, res_idx = 0, res_data = 0, res_last = 0.
  - node_done = 0, overflow = 0, collect_stall = 0.
- Reset mid-operation discards any partial accumulation and any undrained bank. No output handshake completes after rst_n falls.
- Inputs are sign-extended to ACC_SIZE before adding. Accumulator lanes are independent.
- Non-final sample (mac_ready and cnt < NUM_NEIGH-1): acc_k <= acc_k + mac_out_k; cnt <= cnt+1.
- Final sample (mac_ready and cnt == NUM_NEIGH-1):
  - Accepted if state == EMPTY, or the lane-3 handshake (res_valid && res_ready && res_idx==3) completes in the same cycle.
  - On accept: bank_k <= post(acc_k + mac_out_k); acc_k <= 0; cnt <= 0.
  - On accept: state <= FULL; res_idx <= 0; node_done pulses the next cycle, coincident with the first res_valid.
  - Otherwise the sample is dropped: overflow <= 1; acc and cnt hold.
- post(s):
  - t = s >>> SHIFT (arithmetic shift).
  - Activation applied to t (see Optional Feature).
  - Saturate to the OUT_SIZE signed range [-2^(OUT_SIZE-1), 2^(OUT_SIZE-1)-1].
- FSM EMPTY: res_valid = 0.
- FSM FULL:
  - res_valid = 1; res_data = bank[res_idx]; res_last = (res_idx==3).
  - On handshake: res_idx increments.
  - On the handshake with res_idx==3: state <= EMPTY, unless a final sample is accepted the same cycle (state stays FULL, res_idx <= 0, new bank shown next cycle).
- res_valid, once high, stays high and res_data stays stable until the handshake, regardless of res_ready.
- collect_stall = (cnt == NUM_NEIGH-1) && (state == FULL). Registered-free combinational output.
- Non-final samples are always accepted in either state. The accumulator never stalls.
- mac_ready is never back-pressured. Dropping is the only loss mechanism, and is always flagged by overflow.
- Latency: final mac_ready edge to res_valid high = 1 cycle. A node drains in at least 4 cycles.

Optional Feature:
- Macro: COLLECT_RELU_EN.
- Defined: ReLU; any negative t becomes 0 before saturation. Outputs lie in [0, 2^(OUT_SIZE-1)-1].
- Undefined: no activation; full signed saturation of t.

Test Plan (NUM_NEIGH=4, SHIFT=4, OUT_SIZE=5):
- Basic node: 4 mac_ready pulses with lanes (100, -50, 20, 8), res_ready=1.
  - Sums are 400, -200, 80, 32.
  - With COLLECT_RELU_EN: res_data = 15, 0, 5, 2 on res_idx 0..3; res_last on the 4th; node_done once.
  - Without the macro: 15, -13, 5, 2.
- Backpressure: same stimulus with res_ready low for 5 cycles after res_valid rises.
  - res_valid stays 1 and res_data stays 15 throughout; all 4 lanes then emerge in order.
- Stall/overflow: hold res_ready=0 and send a second node's 4 samples.
  - collect_stall=1 after the 3rd sample.
  - The 4th sample sets overflow=1; acc and cnt hold.
  - Releasing res_ready and resending the final sample completes the node with no loss.
- Back-to-back: the second node's final mac_ready coincides with the lane-3 handshake.
  - res_valid stays 1 continuously; next res_idx=0 shows the new bank; overflow stays 0.
- Mid-operation reset: pulse rst_n low after 2 samples, or during a drain at res_idx=2.
  - All outputs return to their reset values immediately.
  - A following full node of (16, 16, 16, 16) per sample yields 4 on each lane.
